led_seq_ctrl: RTL
=================

// Module: led_seq_ctrl
//
// PURPOSE
//  Sequencer for the 6-LED bar display. It replaces the free-running
//  prescaler -> counter -> pattern-decoder chain with one controller.
//  - start/stop button; pause input
//  - four selectable patterns; four speed settings
//  Sits between board I/O (button, DIP switches) and the active-low LED pins.
//
// PARAMETERS
//  TICK_DIV  1_350_000  clk cycles per step at speed 0 (27 MHz board clock)
//  N_LEDS    6          LED count; patterns are defined for 6 only
//
// PORTS
//  clk     in   1  system clock
//  rst     in   1  asynchronous, active-low reset
//  start   in   1  raw start/stop button, active-high, asynchronous to clk
//  pause   in   1  level; high freezes the sequence (already synchronous)
//  mode    in   2  pattern select: 00 FILL, 01 SHIFT, 10 BOUNCE, 11 BLINK
//  speed   in   2  step period = TICK_DIV << speed (x1, x2, x4, x8)
//  leds    out  6  LED drive, active-low (1 = off)
//  busy    out  1  high in RUN or PAUSED
//  step    out  4  current step index (debug)
//
// BEHAVIOUR
//  Reset values: state=IDLE, leds=6'b111111, busy=0, step=0, prescaler=0,
//  mode_q=00.
//
//  start input conditioning
//  - 2-FF synchronizer, then rising-edge detect -> start_p (1-cycle pulse).
//  - start_p asserts 3 clk cycles after the start rise.
//
//  Prescaler
//  - Counts 0 .. (TICK_DIV<<speed)-1.
//  - tick = 1 on the terminal count; the counter then wraps to 0.
//  - Width: $clog2(TICK_DIV*8).
//  - A speed change takes effect immediately. If the count is already >= the
//    new terminal count, the counter wraps to 0 on the next cycle and no
//    tick is issued for that wrap.
//
//  FSM
//  - IDLE:   leds=all off. On start_p -> RUN: step=0, prescaler=0,
//            mode_q<=mode.
//  - RUN:    on tick, step <= (step==LEN(mode_q)-1) ? 0 : step+1.
//            On wrap to 0, mode_q<=mode; mode changes take effect only at
//            a wrap. pause=1 -> PAUSED. start_p -> IDLE.
//  - PAUSED: prescaler and step frozen; leds hold their value.
//            pause=0 -> RUN; the prescaler resumes from its held count.
//            start_p -> IDLE.
//  - Priority within a cycle: start_p > pause > tick.
//    A tick coinciding with start_p or pause does not advance step.
//
//  Patterns (pat is active-high; leds <= ~pat)
//  - FILL   (LEN 10): s<=5: (1<<(s+1))-1.  s>=6: 6'b111111<<(s-4).
//  - SHIFT  (LEN 6):  1<<s.
//  - BOUNCE (LEN 10): s<=5: 1<<s.  s>=6: 1<<(10-s).
//  - BLINK  (LEN 2):  s=0: 6'b111111.  s=1: 6'b000000.
//
//  Timing and reset
//  - leds is registered and lags step by one clk cycle.
//  - busy is registered from the FSM state.
//  - Reset mid-operation: immediate return to the reset values; no partial
//    pattern is retained.
//
// STRUCTURE
//  - Package led_seq_pkg:
//    state_e {IDLE, RUN, PAUSED}; mode_e {FILL, SHIFT, BOUNCE, BLINK};
//    LEN_* constants; function pattern(mode_e, logic [3:0]) -> logic [5:0].
//  - Sub-module led_tick_gen: prescaler + speed shift, outputs tick;
//    inputs en and clr.
//  - Top: synchronizer, edge detect, FSM, step counter, output register.
//
// TESTING  (TICK_DIV=4 for simulation)
//  1. Reset while RUN with leds=~6'b000111 -> leds=6'b111111, busy=0,
//     step=0 asynchronously.
//  2. FILL, speed=0, start pulse -> busy=1. leds then steps every 4 clk:
//     ~000001, ~000011, ... ~111111, ~111100, ... ~100000, ~000001
//     (wrap after 10 steps).
//  3. BOUNCE, speed=2 -> step period 16 clk. leds sequence:
//     ~000001 .. ~100000, ~010000, ~001000, ~000100, ~000010, then repeats.
//  4. SHIFT run; switch mode to BLINK at step 2 -> SHIFT continues to step 5.
//     The next step (index 0) shows ~111111, then ~000000.
//  5. pause=1 at step 3 for 50 clk -> step and leds frozen. After pause=0,
//     step 4 arrives after the remaining prescaler count, not after a full
//     period.
//  6. start pulse coinciding with tick in RUN -> IDLE, leds=6'b111111,
//     step unchanged on that cycle. A second start pulse -> RUN from step 0.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared types, sequence lengths and the LED pattern decoder for led_seq_ctrl.
package led_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        FILL   = 2'b00,
        SHIFT  = 2'b01,
        BOUNCE = 2'b10,
        BLINK  = 2'b11
    } mode_e;

    // Patterns are only defined for a 6-LED bar.
    localparam int PAT_W = 6;

    localparam logic [3:0] LEN_FILL   = 4'd10;
    localparam logic [3:0] LEN_SHIFT  = 4'd6;
    localparam logic [3:0] LEN_BOUNCE = 4'd10;
    localparam logic [3:0] LEN_BLINK  = 4'd2;

    // Number of steps in one full cycle of a pattern.
    function automatic logic [3:0] pattern_len(input mode_e m);
        logic [3:0] len;
        case (m)
            FILL:    len = LEN_FILL;
            SHIFT:   len = LEN_SHIFT;
            BOUNCE:  len = LEN_BOUNCE;
            BLINK:   len = LEN_BLINK;
            default: len = LEN_FILL;
        endcase
        return len;
    endfunction

    // Active-high LED image for a given pattern and step index.
    // A 7-bit intermediate keeps the shifted/subtracted forms exact before
    // trimming to the bar width.
    function automatic logic [PAT_W-1:0] pattern(input mode_e m, input logic [3:0] s);
        logic [6:0] w;
        w = 7'd0;
        case (m)
            FILL: begin
                if (s <= 4'd5) begin
                    w = (7'd1 << (s + 4'd1)) - 7'd1;
                end else begin
                    w = 7'b0111111 << (s - 4'd4);
                end
            end
            SHIFT: begin
                w = 7'd1 << s;
            end
            BOUNCE: begin
                if (s <= 4'd5) begin
                    w = 7'd1 << s;
                end else begin
                    w = 7'd1 << (4'd10 - s);
                end
            end
            BLINK: begin
                if (s == 4'd0) begin
                    w = 7'b0111111;
                end else begin
                    w = 7'd0;
                end
            end
            default: begin
                w = 7'd0;
            end
        endcase
        return w[PAT_W-1:0];
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler: counts 0 .. (TICK_DIV << speed) - 1 and flags the terminal
// count. A speed change applies at once; a count already past the new
// terminal value folds back to 0 silently (no tick for that wrap).
import led_seq_pkg::*;

module led_tick_gen #(
    parameter int TICK_DIV = 1_350_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic [1:0] speed,
    output logic       tick
);

    localparam int CW = $clog2(TICK_DIV * 8);

    logic [CW:0]   period_s;
    logic [CW-1:0] term_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          tick_s;

    // Terminal count for the currently selected speed.
    always_comb begin
        period_s = (CW+1)'(TICK_DIV) << speed;
        term_s   = CW'(period_s - (CW+1)'(1));
    end

    // Next count and tick; clear wins, disabled holds the count.
    always_comb begin
        cnt_nxt_s = cnt_r;
        tick_s    = 1'b0;
        if (clr) begin
            cnt_nxt_s = {CW{1'b0}};
        end else if (en) begin
            if (cnt_r == term_s) begin
                tick_s    = 1'b1;
                cnt_nxt_s = {CW{1'b0}};
            end else if (cnt_r > term_s) begin
                cnt_nxt_s = {CW{1'b0}};
            end else begin
                cnt_nxt_s = cnt_r + CW'(1);
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign tick = tick_s;

endmodule

// File: rtl/led_seq_ctrl.sv
// 6-LED bar sequencer: start/stop button conditioning, run/pause FSM,
// step counter and registered active-low LED drive.
import led_seq_pkg::*;

module led_seq_ctrl #(
    parameter int TICK_DIV = 1_350_000,
    parameter int N_LEDS   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause,
    input  logic [1:0]        mode,
    input  logic [1:0]        speed,
    output logic [N_LEDS-1:0] leds,
    output logic              busy,
    output logic [3:0]        step
);

    logic        sync1_r;
    logic        sync2_r;
    logic        sync3_r;
    logic        start_p_r;

    state_e      state_r;
    state_e      state_nxt_s;
    logic [3:0]  step_r;
    logic [3:0]  step_nxt_s;
    mode_e       mode_q_r;
    mode_e       mode_nxt_s;

    logic        tick_s;
    logic        en_s;
    logic        clr_s;
    logic        last_s;

    logic [N_LEDS-1:0] leds_r;
    logic              busy_r;

    // Two-stage synchronizer on the raw button, then a registered rising-edge pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            sync3_r   <= 1'b0;
            start_p_r <= 1'b0;
        end else begin
            sync1_r   <= start;
            sync2_r   <= sync1_r;
            sync3_r   <= sync2_r;
            start_p_r <= sync2_r & ~sync3_r;
        end
    end

    // Prescaler runs only in RUN on cycles where neither start nor pause
    // pre-empts the tick; it sits at zero while idle so a restart is a full period.
    assign en_s  = (state_r == RUN) && !start_p_r && !pause;
    assign clr_s = (state_r == IDLE);

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .en    (en_s),
        .clr   (clr_s),
        .speed (speed),
        .tick  (tick_s)
    );

    assign last_s = (step_r == (pattern_len(mode_q_r) - 4'd1));

    // Next state, step and latched mode; start beats pause beats tick.
    always_comb begin
        state_nxt_s = state_r;
        step_nxt_s  = step_r;
        mode_nxt_s  = mode_q_r;
        case (state_r)
            IDLE: begin
                if (start_p_r) begin
                    state_nxt_s = RUN;
                    step_nxt_s  = 4'd0;
                    mode_nxt_s  = mode_e'(mode);
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (start_p_r) begin
                    state_nxt_s = IDLE;
                end else if (pause) begin
                    state_nxt_s = PAUSED;
                end else if (tick_s) begin
                    if (last_s) begin
                        step_nxt_s = 4'd0;
                        mode_nxt_s = mode_e'(mode);
                    end else begin
                        step_nxt_s = step_r + 4'd1;
                    end
                end else begin
                    state_nxt_s = RUN;
                end
            end
            PAUSED: begin
                if (start_p_r) begin
                    state_nxt_s = IDLE;
                end else if (!pause) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = PAUSED;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                step_nxt_s  = 4'd0;
                mode_nxt_s  = FILL;
            end
        endcase
    end

    // FSM state, step index and latched pattern select.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            step_r   <= 4'd0;
            mode_q_r <= FILL;
        end else begin
            state_r  <= state_nxt_s;
            step_r   <= step_nxt_s;
            mode_q_r <= mode_nxt_s;
        end
    end

    // LED drive and busy flag, registered one cycle behind step/state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            leds_r <= {N_LEDS{1'b1}};
            busy_r <= 1'b0;
        end else begin
            if (state_r == IDLE) begin
                leds_r <= {N_LEDS{1'b1}};
            end else begin
                leds_r <= ~pattern(mode_q_r, step_r);
            end
            busy_r <= (state_r != IDLE);
        end
    end

    assign leds = leds_r;
    assign busy = busy_r;
    assign step = step_r;

endmodule
